// File: rtl/jk_mod_counter.sv
// Modulo-MODULUS up/down counter whose state bits update as JK flip-flops.
// Each bit's j/k pair is derived from clear/load/count controls, with a wrap override at the range ends.
module jk_mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             load_err
);

    // One extra bit so MODULUS == 2**WIDTH still compares correctly.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] tog_up, tog_dn, tog;
    logic [WIDTH-1:0] j, k;
    logic [WIDTH-1:0] load_data, target;
    logic             load_bad, wrap_hit;

    always_comb begin
        tog_up[0] = 1'b1;
        tog_dn[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            tog_up[i] = tog_up[i-1] & cnt_q[i-1];
            tog_dn[i] = tog_dn[i-1] & ~cnt_q[i-1];
        end
        tog       = up ? tog_up : tog_dn;
        load_bad  = {1'b0, load_val} >= MOD_EXT;
        load_data = load_bad ? MAX_V : load_val;
        wrap_hit  = up ? (cnt_q == MAX_V) : (cnt_q == '0);
        target    = up ? '0 : MAX_V;

        j      = '0;
        k      = '0;
        wrap_d = 1'b0;
        err_d  = err_q;
        if (clear) begin
            k     = '1;
            err_d = 1'b0;
        end else if (load) begin
            j     = load_data;
            k     = ~load_data;
            err_d = err_q | load_bad;
        end else if (en) begin
            if (wrap_hit) begin
                // Force every bit straight to the wrap target instead of rippling.
                j      = target;
                k      = ~target;
                wrap_d = 1'b1;
            end else begin
                j = tog;
                k = tog;
            end
        end
        cnt_d = (j & ~cnt_q) | (~k & cnt_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign q        = cnt_q;
    assign wrap     = wrap_q;
    assign load_err = err_q;

endmodule
